// File: rtl/back_memory_bank_if.sv
// Bus bundle for back_memory_bank: video read port, processor write handshake,
// and bulk-clear control/status.
interface back_memory_bank_if #(
    parameter int unsigned DATA_WIDTH = 9,
    parameter int unsigned ADDR_WIDTH = 13
);
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_address;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  wr_valid;
    logic [ADDR_WIDTH-1:0] wr_address;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_ready;
    logic                  wr_done;
    logic                  clear_start;
    logic                  busy;
    logic                  clear_done;

    modport master (
        output rd_en, rd_address, wr_valid, wr_address, wr_data, clear_start,
        input  rd_data, rd_valid, wr_ready, wr_done, busy, clear_done
    );

    modport slave (
        input  rd_en, rd_address, wr_valid, wr_address, wr_data, clear_start,
        output rd_data, rd_valid, wr_ready, wr_done, busy, clear_done
    );
endinterface

// File: rtl/back_memory_bank.sv
// Background colour memory: one single-port RAM shared by a priority video read
// path, a buffered processor write path and a hardware bulk-clear engine.
module back_memory_bank #(
    parameter int unsigned          DATA_WIDTH  = 9,
    parameter int unsigned          ADDR_WIDTH  = 13,
    parameter int unsigned          DEPTH       = 4800,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input logic              clock,
    input logic              reset,
    back_memory_bank_if.slave bus
);

    localparam int unsigned IdxWidth = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0]   DepthExt = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {StIdle, StHold, StClear} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] hold_addr_q, hold_addr_d;
    logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
    logic                  pend_q, pend_d;
    logic                  wr_done_q, wr_done_d;
    logic                  clear_done_q, clear_done_d;
    logic                  rd_pend_q, rd_oob_q, rd_valid_q;
    logic [DATA_WIDTH-1:0] rd_data_q;

    logic                  ram_we, ram_re;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata, ram_q;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic rd_in_range, hold_in_range;
    assign rd_in_range   = {1'b0, bus.rd_address} < DepthExt;
    assign hold_in_range = {1'b0, hold_addr_q} < DepthExt;

    // Port arbitration: video read always wins; held write and clear only use idle slots.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hold_addr_d  = hold_addr_q;
        hold_data_d  = hold_data_q;
        pend_d       = pend_q;
        wr_done_d    = 1'b0;
        clear_done_d = 1'b0;
        ram_we       = 1'b0;
        ram_re       = 1'b0;
        ram_addr     = cnt_q;
        ram_wdata    = CLEAR_VALUE;
        if (bus.rd_en) begin
            ram_re   = rd_in_range;
            ram_addr = bus.rd_address;
        end
        unique case (state_q)
            StIdle: begin
                if (bus.clear_start) begin
                    state_d = StClear;
                    cnt_d   = '0;
                end else if (bus.wr_valid) begin
                    hold_addr_d = bus.wr_address;
                    hold_data_d = bus.wr_data;
                    state_d     = StHold;
                end
            end
            StHold: begin
                if (bus.clear_start) pend_d = 1'b1;
                if (!bus.rd_en) begin
                    ram_we    = hold_in_range;
                    ram_addr  = hold_addr_q;
                    ram_wdata = hold_data_q;
                    wr_done_d = 1'b1;
                    if (pend_q || bus.clear_start) begin
                        state_d = StClear;
                        cnt_d   = '0;
                        pend_d  = 1'b0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StClear: begin
                if (!bus.rd_en) begin
                    ram_we = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == LastAddr) begin
                        state_d      = StIdle;
                        clear_done_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            hold_addr_q  <= '0;
            hold_data_q  <= '0;
            pend_q       <= 1'b0;
            wr_done_q    <= 1'b0;
            clear_done_q <= 1'b0;
            rd_pend_q    <= 1'b0;
            rd_oob_q     <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hold_addr_q  <= hold_addr_d;
            hold_data_q  <= hold_data_d;
            pend_q       <= pend_d;
            wr_done_q    <= wr_done_d;
            clear_done_q <= clear_done_d;
            rd_pend_q    <= bus.rd_en;
            rd_oob_q     <= !rd_in_range;
            rd_valid_q   <= rd_pend_q;
            if (rd_pend_q) rd_data_q <= rd_oob_q ? CLEAR_VALUE : ram_q;
        end
    end

    // RAM array has no reset so it maps onto block memory.
    always_ff @(posedge clock) begin
        if (ram_we) mem[ram_addr[IdxWidth-1:0]] <= ram_wdata;
        if (ram_re) ram_q <= mem[ram_addr[IdxWidth-1:0]];
    end

    assign bus.rd_data    = rd_data_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.wr_ready   = (state_q == StIdle) && !bus.clear_start;
    assign bus.wr_done    = wr_done_q;
    assign bus.busy       = (state_q != StIdle);
    assign bus.clear_done = clear_done_q;

endmodule

// File: tb/tb_back_memory_bank.sv
// Directed bench: a 16-word bank (CLEAR_VALUE 0x111) for clear/handshake cases and
// a default 4800-word bank sharing the same stimulus for range boundaries.
module tb_back_memory_bank;

    logic clock = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    back_memory_bank_if #(.DATA_WIDTH(9), .ADDR_WIDTH(13)) m ();
    back_memory_bank_if #(.DATA_WIDTH(9), .ADDR_WIDTH(13)) b ();

    assign b.rd_en       = m.rd_en;
    assign b.rd_address  = m.rd_address;
    assign b.wr_valid    = m.wr_valid;
    assign b.wr_address  = m.wr_address;
    assign b.wr_data     = m.wr_data;
    assign b.clear_start = 1'b0;

    back_memory_bank #(.DEPTH(16), .CLEAR_VALUE(9'h111)) u_small (
        .clock (clock),
        .reset (reset),
        .bus   (m.slave)
    );

    back_memory_bank u_big (
        .clock (clock),
        .reset (reset),
        .bus   (b.slave)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [12:0] wa;
        logic [8:0]  wd;
        logic [12:0] ra;
        logic [8:0]  exp;
    } vec_t;

    vec_t vecs [4];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_write(input logic [12:0] a, input logic [8:0] d, input bit big,
                            input string nm);
        m.wr_valid = 1'b1; m.wr_address = a; m.wr_data = d; m.rd_en = 1'b0;
        #1;
        check({nm, " wr_ready"}, m.wr_ready, 1);
        step();
        m.wr_valid = 1'b0;
        check({nm, " no early wr_done"}, big ? b.wr_done : m.wr_done, 0);
        step();
        check({nm, " wr_done"}, big ? b.wr_done : m.wr_done, 1);
    endtask

    task automatic do_read(input logic [12:0] a, input logic [8:0] e, input bit big,
                           input string nm);
        m.rd_en = 1'b1; m.rd_address = a;
        step();
        m.rd_en = 1'b0;
        step();
        check({nm, " rd_valid"}, big ? b.rd_valid : m.rd_valid, 1);
        check({nm, " rd_data"}, big ? b.rd_data : m.rd_data, e);
    endtask

    task automatic wait_clear(input bit toggle, output int n, output bit saw_wr);
        n = 0;
        saw_wr = 1'b0;
        while (m.busy && n < 200) begin
            n++;
            if (toggle) m.rd_en = n[0];
            step();
            if (m.wr_done) saw_wr = 1'b1;
        end
        m.rd_en = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        bit saw;
        vecs[0] = '{wa: 13'd5,    wd: 9'h1A5, ra: 13'd5,    exp: 9'h1A5};
        vecs[1] = '{wa: 13'd100,  wd: 9'h0AA, ra: 13'd100,  exp: 9'h0AA};
        vecs[2] = '{wa: 13'd4799, wd: 9'h155, ra: 13'd4799, exp: 9'h155};
        vecs[3] = '{wa: 13'd0,    wd: 9'h03C, ra: 13'd0,    exp: 9'h03C};

        reset = 1'b1;
        m.rd_en = 1'b0; m.rd_address = '0; m.wr_valid = 1'b0;
        m.wr_address = '0; m.wr_data = '0; m.clear_start = 1'b0;
        #1;
        check("reset rd_data", m.rd_data, 0);
        check("reset rd_valid", m.rd_valid, 0);
        check("reset wr_done", m.wr_done, 0);
        check("reset clear_done", m.clear_done, 0);
        check("reset busy", m.busy, 0);
        check("reset wr_ready", m.wr_ready, 1);
        step(); step();
        reset = 1'b0;
        step();

        // Write/readback vectors on the 4800-word bank.
        for (int i = 0; i < 4; i++) begin
            do_write(vecs[i].wa, vecs[i].wd, 1'b1, $sformatf("vec%0d", i));
            do_read(vecs[i].ra, vecs[i].exp, 1'b1, $sformatf("vec%0d rb", i));
        end

        // Write held off by 10 cycles of continuous reads.
        m.wr_valid = 1'b1; m.wr_address = 13'd7; m.wr_data = 9'h0F0;
        m.rd_en = 1'b1; m.rd_address = 13'd5;
        #1;
        check("stall accept wr_ready", m.wr_ready, 1);
        step();
        m.wr_valid = 1'b0;
        for (int i = 1; i < 10; i++) begin
            check($sformatf("stall c%0d wr_ready", i), m.wr_ready, 0);
            check($sformatf("stall c%0d wr_done", i), b.wr_done, 0);
            step();
        end
        check("stall last wr_done", b.wr_done, 0);
        check("stall read during hold", b.rd_data, 9'h1A5);
        m.rd_en = 1'b0;
        step();
        check("stall commit wr_done", b.wr_done, 1);
        do_read(13'd7, 9'h0F0, 1'b1, "stall rb");

        // Out-of-range write/read on the 4800-word bank.
        do_write(13'd4800, 9'h1FF, 1'b1, "oob");
        do_read(13'd0, 9'h03C, 1'b1, "oob addr0");
        do_read(13'd4799, 9'h155, 1'b1, "oob addr4799");
        do_read(13'd4800, 9'h000, 1'b1, "oob read");

        // Bulk clear with reads idle.
        m.clear_start = 1'b1;
        step();
        m.clear_start = 1'b0;
        wait_clear(1'b0, n, saw);
        check("clear cycles", n, 16);
        check("clear_done", m.clear_done, 1);
        step();
        check("clear_done pulse", m.clear_done, 0);
        for (int i = 0; i < 16; i++) do_read(13'(i), 9'h111, 1'b0, $sformatf("clr a%0d", i));
        do_read(13'd16, 9'h111, 1'b0, "small oob read");

        // Bulk clear with reads on every other cycle.
        do_write(13'd2, 9'h0AB, 1'b0, "pre2");
        do_write(13'd9, 9'h0CD, 1'b0, "pre9");
        m.clear_start = 1'b1;
        step();
        m.clear_start = 1'b0;
        wait_clear(1'b1, n, saw);
        check("toggle clear cycles", n, 32);
        check("toggle clear_done", m.clear_done, 1);
        for (int i = 0; i < 16; i++) do_read(13'(i), 9'h111, 1'b0, $sformatf("tclr a%0d", i));

        // Same-cycle clear_start and wr_valid: clear wins.
        do_write(13'd3, 9'h055, 1'b0, "pre3");
        m.clear_start = 1'b1; m.wr_valid = 1'b1; m.wr_address = 13'd3; m.wr_data = 9'h0AB;
        #1;
        check("collide wr_ready", m.wr_ready, 0);
        step();
        m.clear_start = 1'b0; m.wr_valid = 1'b0;
        check("collide busy", m.busy, 1);
        wait_clear(1'b0, n, saw);
        check("collide clear cycles", n, 16);
        check("collide no wr_done", saw, 0);
        check("collide clear_done", m.clear_done, 1);
        do_read(13'd3, 9'h111, 1'b0, "collide rb");

        // clear_start during HOLD: held write commits first, then the clear.
        m.wr_valid = 1'b1; m.wr_address = 13'd4; m.wr_data = 9'h0CD;
        step();
        m.wr_valid = 1'b0; m.rd_en = 1'b1; m.clear_start = 1'b1;
        #1;
        check("hold clear wr_ready", m.wr_ready, 0);
        step();
        m.clear_start = 1'b0; m.rd_en = 1'b0;
        check("hold clear still held", m.wr_done, 0);
        step();
        check("hold clear wr_done", m.wr_done, 1);
        check("hold clear busy", m.busy, 1);
        check("hold clear no clear_done", m.clear_done, 0);
        wait_clear(1'b0, n, saw);
        check("hold clear cycles", n, 16);
        check("hold clear clear_done", m.clear_done, 1);
        do_read(13'd4, 9'h111, 1'b0, "hold clear rb");

        // Reset three writes into a clear.
        for (int i = 0; i < 16; i++) do_write(13'(i), 9'(9'h040 + i), 1'b0, $sformatf("fill%0d", i));
        m.clear_start = 1'b1;
        step();
        m.clear_start = 1'b0;
        step(); step(); step();
        reset = 1'b1;
        #1;
        check("abort busy", m.busy, 0);
        check("abort rd_valid", m.rd_valid, 0);
        check("abort rd_data", m.rd_data, 0);
        check("abort wr_done", m.wr_done, 0);
        check("abort clear_done", m.clear_done, 0);
        step();
        reset = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (m.clear_done) saw = 1'b1;
        end
        check("abort no clear_done", saw, 0);
        for (int i = 0; i < 16; i++)
            do_read(13'(i), (i < 3) ? 9'h111 : 9'(9'h040 + i), 1'b0, $sformatf("abort a%0d", i));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/back_memory_bank.md
Name: back_memory_bank

Overview:
- Parametrised successor to the single-port background colour memory.
- One synchronous single-port RAM is shared between the video read path, which has absolute priority, and a processor write path with a valid/ready handshake and a one-entry hold buffer.
- Adds a hardware bulk-clear mode that fills the whole memory with a constant.
- Adds explicit completion pulses for writes and clears.
- Sits between the instruction decoder/processor write bus and the VGA pixel pipeline.

Parameters:
DATA_WIDTH, 9, bits per stored colour word (RGB 3:3:3)
ADDR_WIDTH, 13, address bus width
DEPTH, 4800, number of implemented words; must be ≤ 2^ADDR_WIDTH
CLEAR_VALUE, 0, word written to every location by a clear operation

Ports:
clock  in  1  system clock; all logic on rising edge
reset  in  1  asynchronous, active-high reset
rd_en  in  1  video read request; sampled every cycle
rd_address  in  ADDR_WIDTH  video read address
rd_data  out  DATA_WIDTH  registered read data
rd_valid  out  1  rd_data holds the result of the read issued 2 cycles earlier
wr_valid  in  1  write request
wr_address  in  ADDR_WIDTH  write address
wr_data  in  DATA_WIDTH  write data
wr_ready  out  1  write accepted this cycle when wr_valid=1
wr_done  out  1  one-cycle pulse: buffered write committed, or dropped if out of range
clear_start  in  1  start bulk clear; sampled when accepted
busy  out  1  state ≠ IDLE
clear_done  out  1  one-cycle pulse after the last clear word is written

Behaviour:
- Reset (async, active-high):
  - State → IDLE; clear counter → 0; hold register → 0; clear-pending flag → 0.
  - rd_data = 0; rd_valid = 0; wr_done = 0; clear_done = 0; busy = 0.
  - RAM contents are not initialised.
- Read path, fixed latency 2:
  - Cycle N: rd_en=1 with rd_address.
  - Cycle N+1: RAM output is available.
  - Cycle N+2: rd_data and rd_valid=1 are registered outputs.
  - rd_valid tracks rd_en delayed by 2 cycles.
  - rd_address ≥ DEPTH returns CLEAR_VALUE; the RAM is not accessed.
  - Reads are never stalled; a read always wins the RAM port.
- RAM port mux, per cycle, in priority order:
  1. rd_en=1 → read.
  2. HOLD → commit the held write.
  3. CLEAR → write CLEAR_VALUE at the counter address.
  4. Otherwise idle.
- State machine, states IDLE / HOLD / CLEAR:
  - IDLE:
    - wr_ready = !clear_start (combinational).
    - clear_start=1 → CLEAR, counter = 0. clear_start takes precedence over a same-cycle wr_valid; that write is not accepted.
    - else wr_valid=1 → capture address and data into the hold register → HOLD.
  - HOLD:
    - wr_ready = 0.
    - The first cycle with rd_en=0 is the commit cycle: RAM write, or no write if wr_address ≥ DEPTH. wr_done=1 in the following cycle.
    - Leaves HOLD at the commit edge: to CLEAR if clear-pending is set (clear_start seen during HOLD, then flag cleared), otherwise to IDLE.
    - Write throughput is therefore at most one write per 2 cycles.
  - CLEAR:
    - wr_ready = 0; clear_start is ignored.
    - Each cycle with rd_en=0 writes CLEAR_VALUE at the counter address and increments the counter.
    - Cycles with rd_en=1 freeze the counter.
    - After the write at address DEPTH-1 → IDLE; clear_done=1 in the following cycle.
    - Reads during CLEAR return current contents, which may be partially cleared.
- Read-after-write:
  - A write committed in cycle C is visible to a read issued in C+1.
  - A read issued in cycle C itself cannot coincide with the commit, because reads have priority.
- Reset mid-HOLD discards the held write; no wr_done is produced.
- Reset mid-CLEAR aborts the clear; memory stays partially cleared; no clear_done is produced.
- wr_done and clear_done are never asserted in the same cycle.

Test Plan:
1. Reset, then write addr 5 = 9'h1A5 with rd_en=0 → wr_ready=1 on the accept cycle, wr_done pulses 2 cycles later. Read addr 5 → rd_data=9'h1A5, rd_valid=1, exactly 2 cycles after rd_en.
2. Write addr 7 = 9'h0F0 while rd_en held at 1 for 10 cycles → no commit and wr_ready=0 throughout; commit on the first rd_en=0 cycle, wr_done one cycle later; readback gives 9'h0F0.
3. clear_start with DEPTH=16, CLEAR_VALUE=9'h111 (override), rd_en=0 → busy for 16 cycles, clear_done pulse one cycle after the last write; reads of 0..15 all return 9'h111. Repeat with rd_en toggling 50% → clear takes 32 cycles, same result.
4. Same-cycle clear_start and wr_valid in IDLE → wr_ready=0, write not taken, clear runs. clear_start asserted during HOLD → held write commits first, then the clear runs.
5. Write and read to addr 4800 (DEPTH=4800) → no RAM change at addr 0 or 4799; wr_done still pulses; read returns CLEAR_VALUE.
6. Assert reset 3 cycles into a clear of DEPTH=16 → all outputs 0 immediately; addresses 0..2 hold CLEAR_VALUE, address 3 onward unchanged; no clear_done.
